// File: rtl/pipeline_set_arbiter_if.sv
// Bus between the requesters and the pipeline set arbiter. The requester
// side (master) presents requests and preload images. The arbiter side
// (slave) returns ownership, completion and the chain preload strobe.
interface pipeline_set_arbiter_if #(
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5,
  parameter int NUM_REQ          = 4
);
  logic [NUM_REQ-1:0]                            req;
  logic [NUM_REQ*BIT_WIDTH*NUMBER_OF_STAGES-1:0] req_data;
  logic [NUM_REQ-1:0]                            grant;
  logic [NUM_REQ-1:0]                            done;
  logic                                          set;
  logic [BIT_WIDTH*NUMBER_OF_STAGES-1:0]         set_data;
  logic                                          busy;

  modport master (
    output req, req_data,
    input  grant, done, set, set_data, busy
  );

  modport slave (
    input  req, req_data,
    output grant, done, set, set_data, busy
  );
endinterface

// File: rtl/pipeline_set_arbiter.sv
// Round-robin arbiter sharing one set-capable pipeline register chain.
// The winner's image is preloaded for one cycle, then everyone waits until
// that image has drained to the chain output, then done pulses to the owner.
module pipeline_set_arbiter #(
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5,
  parameter int NUM_REQ          = 4,
  parameter int PTR_W            = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pipeline_set_arbiter_if.slave   bus
);

  localparam int IMG_W = BIT_WIDTH * NUMBER_OF_STAGES;
  localparam int CNT_W = (NUMBER_OF_STAGES > 1) ? $clog2(NUMBER_OF_STAGES) : 1;

  if (NUMBER_OF_STAGES < 1) begin : g_bad_stages
    $error("pipeline_set_arbiter: NUMBER_OF_STAGES must be >= 1");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("pipeline_set_arbiter: NUM_REQ must be >= 2");
  end
  if ((2 ** PTR_W) < NUM_REQ) begin : g_bad_ptr_w
    $error("pipeline_set_arbiter: PTR_W too narrow for NUM_REQ");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant_q, grant_nxt;
  logic [NUM_REQ-1:0]  done_q, done_nxt;
  logic                set_q, set_nxt;
  logic [IMG_W-1:0]    set_data_q, set_data_nxt;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]    winner, winner_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PTR_W-1:0]    pick;
  logic [PTR_W-1:0]    idx;
  logic                found;

  // Round-robin search: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and next-output logic; the counter drains the image one stage per cycle.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    done_nxt     = '0;
    set_nxt      = 1'b0;
    set_data_nxt = set_data_q;
    rr_ptr_nxt   = rr_ptr;
    winner_nxt   = winner;
    cnt_nxt      = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = LOAD;
          winner_nxt   = pick;
          grant_nxt    = NUM_REQ'(1) << pick;
          set_nxt      = 1'b1;
          set_data_nxt = bus.req_data[int'(pick)*IMG_W +: IMG_W];
        end
      end
      LOAD: begin
        cnt_nxt = CNT_W'(NUMBER_OF_STAGES - 1);
        if (NUMBER_OF_STAGES == 1) begin
          state_nxt = DONE;
          done_nxt  = grant_q;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
          done_nxt  = grant_q;
        end
      end
      DONE: begin
        state_nxt    = IDLE;
        grant_nxt    = '0;
        set_data_nxt = '0;
        rr_ptr_nxt   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      set_q      <= 1'b0;
      set_data_q <= '0;
      rr_ptr     <= '0;
      winner     <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      done_q     <= done_nxt;
      set_q      <= set_nxt;
      set_data_q <= set_data_nxt;
      rr_ptr     <= rr_ptr_nxt;
      winner     <= winner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.set      = set_q;
  assign bus.set_data = set_data_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_pipeline_set_arbiter.sv
// Self-checking bench for pipeline_set_arbiter: directed scenarios plus a
// randomized phase, compared each cycle against an ownership/age model and a
// behavioural pipeline chain fed from the arbiter's set/set_data outputs.
module tb_pipeline_set_arbiter;
  localparam int BW  = 10;
  localparam int NS  = 5;
  localparam int NR  = 4;
  localparam int IMG = BW * NS;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: current owner (-1 when free), cycles since grant, pointer, image.
  int             m_owner;
  int             m_age;
  int             m_rr;
  logic [IMG-1:0] m_image;

  pipeline_set_arbiter_if #(.BIT_WIDTH(BW), .NUMBER_OF_STAGES(NS), .NUM_REQ(NR)) bus5 ();
  pipeline_set_arbiter_if #(.BIT_WIDTH(BW), .NUMBER_OF_STAGES(1),  .NUM_REQ(NR)) bus1 ();

  pipeline_set_arbiter #(.BIT_WIDTH(BW), .NUMBER_OF_STAGES(NS), .NUM_REQ(NR), .PTR_W(2)) dut5 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus5)
  );

  pipeline_set_arbiter #(.BIT_WIDTH(BW), .NUMBER_OF_STAGES(1), .NUM_REQ(NR), .PTR_W(2)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  // Behavioural set-capable chain: parallel preload on set, otherwise shift toward the output.
  logic [BW-1:0] chain [NS];
  logic [BW-1:0] chain_out;
  assign chain_out = chain[NS-1];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) chain[i] <= '0;
    end else if (bus5.set) begin
      for (int i = 0; i < NS; i++) chain[i] <= bus5.set_data[i*BW +: BW];
    end else begin
      for (int i = NS-1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= '0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int firstReq(input logic [NR-1:0] r, input int from);
    for (int i = 0; i < NR; i++) begin
      if (r[(from + i) % NR]) return (from + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR*IMG-1:0] randData();
    logic [NR*IMG-1:0] d;
    d = '0;
    for (int i = 0; i < NR*NS; i++) d[i*BW +: BW] = BW'($urandom);
    return d;
  endfunction

  task automatic modelReset();
    m_owner = -1;
    m_age   = 0;
    m_rr    = 0;
    m_image = '0;
  endtask

  // One clock edge of the model: free -> pick a winner; owned -> age until NS, then release.
  task automatic modelEdge();
    int w;
    if (m_owner < 0) begin
      w = firstReq(bus5.req, m_rr);
      if (w >= 0) begin
        m_owner = w;
        m_age   = 0;
        m_image = bus5.req_data[w*IMG +: IMG];
      end
    end else begin
      m_age++;
      if (m_age > NS) begin
        m_rr    = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
  endtask

  task automatic checkOutput();
    logic [NR-1:0] eg;
    eg = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    chk("grant",    64'(bus5.grant),    64'(eg));
    chk("done",     64'(bus5.done),     64'((m_owner >= 0 && m_age == NS) ? eg : '0));
    chk("set",      64'(bus5.set),      64'(m_owner >= 0 && m_age == 0));
    chk("set_data", 64'(bus5.set_data), 64'((m_owner >= 0) ? m_image : '0));
    chk("busy",     64'(bus5.busy),     64'(m_owner >= 0));
    if (m_owner >= 0 && m_age >= 1)
      chk("chain_out", 64'(chain_out), 64'(m_image[(NS-m_age)*BW +: BW]));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*IMG-1:0] d);
    bus5.req      = r;
    bus5.req_data = d;
  endtask

  initial begin
    logic [NR*IMG-1:0] d;
    logic [NR*IMG-1:0] d1;
    logic [NR*IMG-1:0] d2;
    int q_owner[$];
    int q_cyc[$];
    int exp_order[5];
    int cyc;

    exp_order = '{0, 1, 2, 3, 0};
    bus5.req = '0; bus5.req_data = '0;
    bus1.req = '0; bus1.req_data = '0;
    modelReset();
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) stepCycle();

    $display("[TB] single request on requester 2");
    d = '0;
    for (int s = 0; s < NS; s++) d[2*IMG + s*BW +: BW] = BW'(s + 1);
    applyStimulus(4'b0100, d);
    stepCycle();
    chk("t1_grant", 64'(bus5.grant), 64'(4'b0100));
    chk("t1_set", 64'(bus5.set), 64'(1'b1));
    chk("t1_set_data", 64'(bus5.set_data), 64'({10'h005, 10'h004, 10'h003, 10'h002, 10'h001}));
    applyStimulus(4'b0000, d);
    for (int i = 0; i < 5; i++) stepCycle();
    chk("t6_done", 64'(bus5.done), 64'(4'b0100));
    chk("t6_chain", 64'(chain_out), 64'(10'h001));
    stepCycle();
    stepCycle();

    $display("[TB] all requesters held from reset");
    reset_n = 1'b0;
    modelReset();
    applyStimulus(4'b1111, randData());
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();
    cyc = 0;
    for (int i = 0; i < 36; i++) begin
      stepCycle();
      cyc++;
      for (int b = 0; b < NR; b++) begin
        if (bus5.done[b]) begin
          q_owner.push_back(b);
          q_cyc.push_back(cyc);
        end
      end
    end
    chk("rr_done_count", 64'(q_owner.size() >= 5), 64'(1'b1));
    if (q_owner.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", 64'(q_owner[k]), 64'(exp_order[k]));
      for (int k = 1; k < 5; k++) chk("rr_gap", 64'(q_cyc[k] - q_cyc[k-1]), 64'(NS + 2));
    end
    applyStimulus(4'b0000, randData());
    for (int i = 0; i < 8; i++) stepCycle();

    $display("[TB] owner drops request and changes data mid-drain");
    d1 = randData();
    applyStimulus(4'b0001, d1);
    stepCycle();
    stepCycle();
    applyStimulus(4'b1000, randData());
    for (int i = 0; i < 4; i++) stepCycle();
    chk("iso_done", 64'(bus5.done), 64'(4'b0001));
    chk("iso_image", 64'(chain_out), 64'(d1[BW-1:0]));
    stepCycle();
    stepCycle();
    chk("iso_next", 64'(bus5.grant), 64'(4'b1000));

    $display("[TB] reset pulse during drain");
    stepCycle();
    stepCycle();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_grant", 64'(bus5.grant), 64'(0));
    chk("rst_done", 64'(bus5.done), 64'(0));
    chk("rst_set_data", 64'(bus5.set_data), 64'(0));
    chk("rst_busy", 64'(bus5.busy), 64'(0));
    modelReset();
    #1;
    applyStimulus(4'b1010, randData());
    reset_n = 1'b1;
    stepCycle();
    chk("rst_rr", 64'(bus5.grant), 64'(4'b0010));
    applyStimulus(4'b0000, randData());

    $display("[TB] single-stage build");
    d2 = randData();
    bus1.req = 4'b0100;
    bus1.req_data = d2;
    stepCycle();
    chk("n1_set", 64'(bus1.set), 64'(1'b1));
    chk("n1_grant", 64'(bus1.grant), 64'(4'b0100));
    chk("n1_set_data", 64'(bus1.set_data), 64'(d2[2*BW +: BW]));
    chk("n1_done_early", 64'(bus1.done), 64'(0));
    bus1.req = '0;
    stepCycle();
    chk("n1_done", 64'(bus1.done), 64'(4'b0100));
    chk("n1_set_off", 64'(bus1.set), 64'(1'b0));
    chk("n1_grant_hold", 64'(bus1.grant), 64'(4'b0100));
    stepCycle();
    chk("n1_idle_grant", 64'(bus1.grant), 64'(0));
    chk("n1_idle_busy", 64'(bus1.busy), 64'(0));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(NR'($urandom), randData());
      else if ($urandom_range(0, 3) == 0) applyStimulus('0, randData());
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_set_arbiter.md
Name: pipeline_set_arbiter

Overview:
- Round-robin arbiter that shares one set-capable pipeline register chain (BIT_WIDTH wide, NUMBER_OF_STAGES deep, synchronous parallel preload) among NUM_REQ requesters.
- A granted requester's full preload image is driven onto the chain's set/set_data inputs for exactly one cycle.
- The block then holds off all other requesters until the preloaded image has fully drained to the chain output, and signals completion with a one-cycle done pulse.

Parameters:
- BIT_WIDTH, 10, width of one pipeline stage.
- NUMBER_OF_STAGES, 5, depth of the controlled chain. Must be >= 1; 0 is illegal and is flagged by an elaboration-time check.
- NUM_REQ, 4, number of requesters. Must be >= 2.
- PTR_W, 2, requester index width. Must satisfy 2**PTR_W >= NUM_REQ.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester preload request, level.
- req_data  input  NUM_REQ*BIT_WIDTH*NUMBER_OF_STAGES  preload images. Slice r belongs to requester r; stage 0 is the LSB slice.
- grant  output  NUM_REQ  one-hot owner of the chain. Registered.
- done  output  NUM_REQ  one-hot, one-cycle completion pulse to the owner. Registered.
- set  output  1  preload strobe to the chain. Registered.
- set_data  output  BIT_WIDTH*NUMBER_OF_STAGES  preload image to the chain. Registered.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE; grant, done, set and set_data = 0; busy = 0.
  - Round-robin pointer rr_ptr = 0; drain counter = 0.
  - Reset asserted mid-operation aborts immediately. No done pulse is issued. After release, arbitration restarts from requester 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On that edge: latch the winner's req_data slice into set_data, assert grant[winner], and go to LOAD.
  - If no req bit is set, remain in IDLE with all outputs 0.
- LOAD (exactly one cycle):
  - set = 1. set_data holds the latched image, stable for the whole cycle.
  - Drain counter is loaded with NUMBER_OF_STAGES-1.
  - Next state is DRAIN, or DONE when NUMBER_OF_STAGES == 1.
- DRAIN:
  - set = 0; counter decrements once per cycle.
  - When the counter reaches 1, next state is DONE.
  - DRAIN lasts NUMBER_OF_STAGES-1 cycles. This is the number of edges after the preload edge needed for image stage 0 to reach the chain output.
- DONE (one cycle):
  - done[winner] = 1 and grant[winner] is still asserted.
  - On exit: grant cleared, set_data cleared, rr_ptr = (winner+1) mod NUM_REQ, next state IDLE.
- Latency: req seen in IDLE at cycle T gives grant at T+1, set at T+1, and done at T+1+NUMBER_OF_STAGES. An IDLE cycle always separates consecutive operations.
- Owner req handling:
  - Dropping req during LOAD or DRAIN does not abort the operation; done is still pulsed.
  - Holding req through DONE is treated as a new request in the following IDLE and is arbitrated fairly against the others.
- Mid-operation isolation: changes on req or req_data while busy are ignored. Only the image latched at grant is used.
- Invariants:
  - grant and done are each zero or one-hot.
  - done implies grant on the same bit.
  - set is never high outside LOAD.
- Simultaneous requests: round-robin order guarantees each active requester is served within NUM_REQ operations.

Test Plan:
- Reset, then idle for 10 cycles -> grant, done, set, set_data and busy all 0 throughout.
- NUMBER_OF_STAGES=5, BIT_WIDTH=10: req[2]=1 at cycle T with image stages 0..4 = 0x001..0x005 -> grant=4'b0100 at T+1; set=1 for one cycle with set_data={0x005,0x004,0x003,0x002,0x001}; chain output sequence 0x005,0x004,0x003,0x002,0x001; done[2] pulses at T+6 on the same cycle that 0x001 appears at the chain output.
- req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0, with each done separated by exactly 7 cycles (1 IDLE + 1 LOAD + 4 DRAIN + 1 DONE).
- Owner drops req and changes req_data during DRAIN -> operation completes with the original image; done still pulses; no other grant is issued before DONE.
- reset_n pulsed low during DRAIN -> outputs drop to 0 asynchronously with no done; after release, req=4'b1010 grants requester 1 first (rr_ptr back to 0).
- NUMBER_OF_STAGES=1 build: single request -> set at T+1, done at T+2, no DRAIN state visited.
